// File: rtl/tt_sweep_autosym.sv
`default_nettype none
// ============================================================================
//  Module   : tt_sweep_autosym
//  Sweeps all 2^N input vectors through a combinational restriction, captures
//  its truth table, then counts the linear space L_f and its degree.
//  Revision : 1.0
// ============================================================================
module tt_sweep_autosym #(
    parameter int N  = 5,
    parameter int DW = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N-1:0]        x,
    input  logic                y_in,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   tt,
    output logic [N:0]          lf_count,
    output logic [DW-1:0]       deg
);

    localparam int TT = 1 << N;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_SCAN  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [N-1:0] c_LAST = '1;

    logic [1:0]     r_state;
    logic [N-1:0]   r_idx;
    logic [N-1:0]   r_alpha;
    logic [N-1:0]   r_x;
    logic [TT-1:0]  r_tt;
    logic [N:0]     r_lf_count;
    logic [DW-1:0]  r_deg;
    logic           r_busy;
    logic           r_done;

    logic [TT-1:0]  w_perm;
    logic           w_match;
    logic [N:0]     w_lf_next;

    // w_perm[i] = f(i xor alpha); alpha is in L_f when it equals the table
    for (genvar i = 0; i < TT; i++) begin : g_perm
        assign w_perm[i] = r_tt[N'(i) ^ r_alpha];
    end

    assign w_match   = (w_perm == r_tt);
    assign w_lf_next = r_lf_count + (N+1)'(w_match);

    // L_f is a subspace, so the count has exactly one bit set
    function automatic logic [DW-1:0] f_log2(input logic [N:0] v);
        logic [DW-1:0] res;
        res = '0;
        for (int k = 0; k <= N; k++) begin
            if (v[k]) res = DW'(k);
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_alpha    <= '0;
            r_x        <= '0;
            r_tt       <= '0;
            r_lf_count <= '0;
            r_deg      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_x    <= '0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= c_SWEEP;
                        r_idx      <= '0;
                        r_lf_count <= '0;
                        r_deg      <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                c_SWEEP: begin
                    r_tt[r_idx] <= y_in;
                    r_idx       <= r_idx + 1'b1;
                    if (r_idx == c_LAST) begin
                        r_state <= c_SCAN;
                        r_alpha <= '0;
                        r_x     <= '0;
                    end else begin
                        r_x <= r_idx + 1'b1;
                    end
                end
                c_SCAN: begin
                    r_lf_count <= w_lf_next;
                    r_alpha    <= r_alpha + 1'b1;
                    if (r_alpha == c_LAST) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_deg   <= f_log2(w_lf_next);
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_deg   <= f_log2(r_lf_count);
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign x        = r_x;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tt       = r_tt;
    assign lf_count = r_lf_count;
    assign deg      = r_deg;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_autosym.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tt_sweep_autosym
//  Randomized self-checking bench for tt_sweep_autosym against a table model.
//  Revision : 1.0
// ============================================================================
module tb_tt_sweep_autosym;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  x;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [31:0] tt;
    logic [5:0]  lf_count;
    logic [2:0]  deg;

    int          n_vec;
    int          n_err;
    int          mode;
    logic [31:0] rnd_tbl;

    tt_sweep_autosym #(.N(5), .DW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .tt       (tt),
        .lf_count (lf_count),
        .deg      (deg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // restriction under test
    always_comb begin
        case (mode)
            0:       y_in = 1'b0;
            1:       y_in = x[0];
            2:       y_in = x[0] & x[1];
            3:       y_in = &x;
            4:       y_in = ^x;
            default: y_in = rnd_tbl[x];
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_f(input int m, input int v);
        logic [4:0] b;
        b = 5'(v);
        case (m)
            0:       return 1'b0;
            1:       return b[0];
            2:       return b[0] & b[1];
            3:       return b == 5'd31;
            4:       return ($countones(b) % 2) == 1;
            default: return rnd_tbl[v];
        endcase
    endfunction

    function automatic int model_lf(input logic [31:0] t);
        int c;
        bit ok;
        c = 0;
        for (int a = 0; a < 32; a++) begin
            ok = 1'b1;
            for (int i = 0; i < 32; i++)
                if (t[i] != t[i ^ a]) ok = 1'b0;
            if (ok) c++;
        end
        return c;
    endfunction

    function automatic int model_deg(input int c);
        for (int k = 0; k <= 5; k++)
            if ((1 << k) == c) return k;
        return -1;
    endfunction

    task automatic run_sweep(input string tag, input bit extra, input bit use_const,
                             input logic [31:0] c_tt);
        logic [31:0] m_tt;
        int          m_lf;
        int          cyc;
        int          xbad;
        int          bbad;
        bit          got;
        for (int i = 0; i < 32; i++) m_tt[i] = model_f(mode, i);
        m_lf = model_lf(m_tt);
        if (use_const) check({tag, "_model_tt"}, m_tt, c_tt);
        @(negedge clk);
        start = 1'b1;
        cyc = 0; xbad = 0; bbad = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            start = extra && cyc >= 2 && cyc < 60 && ($urandom_range(0, 3) == 0);
            cyc++;
            if (cyc <= 32 && x !== 5'(cyc - 1)) xbad++;
            if (cyc > 32 && cyc <= 64 && x !== 5'd0) xbad++;
            if (cyc <= 64 && busy !== 1'b1) bbad++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) check({tag, "_timeout"}, 0, 1);
        check({tag, "_latency"}, cyc, 65);
        check({tag, "_tt"}, tt, m_tt);
        check({tag, "_lf"}, lf_count, m_lf);
        check({tag, "_deg"}, deg, model_deg(m_lf));
        check({tag, "_xseq"}, xbad, 0);
        check({tag, "_busy"}, bbad, 0);
        check({tag, "_busy_at_done"}, busy, 0);
        // start raised in the done cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        repeat (3) @(negedge clk);
        check({tag, "_no_restart"}, busy, 0);
        check({tag, "_hold_lf"}, lf_count, m_lf);
    endtask

    initial begin
        int cyc;
        int dcount;
        logic [31:0] src;
        logic [4:0]  keep;
        n_vec = 0; n_err = 0;
        mode = 0; rnd_tbl = '0;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", x, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tt", tt, 0);
        check("rst_lf", lf_count, 0);
        check("rst_deg", deg, 0);
        rst = 1'b0;
        @(negedge clk);

        mode = 0; run_sweep("zero", 1'b0, 1'b1, 32'h00000000);
        check("zero_lf_const", lf_count, 32);
        mode = 1; run_sweep("x0", 1'b0, 1'b1, 32'hAAAAAAAA);
        check("x0_deg_const", deg, 4);
        mode = 2; run_sweep("and2", 1'b0, 1'b1, 32'h88888888);
        check("and2_lf_const", lf_count, 8);
        mode = 3; run_sweep("and5", 1'b0, 1'b1, 32'h80000000);
        check("and5_lf_const", lf_count, 1);
        mode = 4; run_sweep("xor5", 1'b1, 1'b1, 32'h96696996);
        check("xor5_lf_const", lf_count, 16);

        // reset during sweep cycle with idx = 10
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 11) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_x", x, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_tt", tt, 0);
        check("midrst_lf", lf_count, 0);
        dcount = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("midrst_no_done", dcount, 0);
        run_sweep("after_rst", 1'b1, 1'b1, 32'hAAAAAAAA);

        for (int r = 0; r < 8; r++) begin
            src  = $urandom;
            keep = 5'($urandom_range(0, 31));
            for (int i = 0; i < 32; i++) rnd_tbl[i] = src[i & int'(keep)];
            mode = 5;
            run_sweep("rand", r[0], 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
